// File: rtl/ie_defs.sv
// Shared instruction-engine definitions: fetch FSM encoding, length codes,
// branch opcodes and the 6502 opcode length table.
package ie_defs;

    typedef enum logic [2:0] {
        REQ_OP = 3'd0,
        CAP_OP = 3'd1,
        REQ_B1 = 3'd2,
        CAP_B1 = 3'd3,
        REQ_B2 = 3'd4,
        CAP_B2 = 3'd5,
        HOLD   = 3'd6
    } fetch_state_e;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    localparam logic [7:0] OP_BPL = 8'h10;
    localparam logic [7:0] OP_BMI = 8'h30;
    localparam logic [7:0] OP_BVC = 8'h50;
    localparam logic [7:0] OP_BVS = 8'h70;
    localparam logic [7:0] OP_BCC = 8'h90;
    localparam logic [7:0] OP_BCS = 8'hB0;
    localparam logic [7:0] OP_BNE = 8'hD0;
    localparam logic [7:0] OP_BEQ = 8'hF0;

    // Anything not listed (implied, accumulator, BRK/RTI/RTS, undefined) is one byte.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            OP_BPL, OP_BMI, OP_BVC, OP_BVS, OP_BCC, OP_BCS, OP_BNE, OP_BEQ:
                len = LEN_2;
            8'h01, 8'h05, 8'h09, 8'h11, 8'h15, 8'h21, 8'h25, 8'h29,
            8'h31, 8'h35, 8'h41, 8'h45, 8'h49, 8'h51, 8'h55, 8'h61,
            8'h65, 8'h69, 8'h71, 8'h75, 8'h81, 8'h85, 8'h91, 8'h95,
            8'hA1, 8'hA5, 8'hA9, 8'hB1, 8'hB5, 8'hC1, 8'hC5, 8'hC9,
            8'hD1, 8'hD5, 8'hE1, 8'hE5, 8'hE9, 8'hF1, 8'hF5:
                len = LEN_2;
            8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 8'h66, 8'h76,
            8'h86, 8'h96, 8'hA2, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6,
            8'hF6:
                len = LEN_2;
            8'h24, 8'h84, 8'h94, 8'hA0, 8'hA4, 8'hB4, 8'hC0, 8'hC4,
            8'hE0, 8'hE4:
                len = LEN_2;
            8'h0D, 8'h1D, 8'h19, 8'h2D, 8'h3D, 8'h39, 8'h4D, 8'h5D,
            8'h59, 8'h6D, 8'h7D, 8'h79, 8'h8D, 8'h9D, 8'h99, 8'hAD,
            8'hBD, 8'hB9, 8'hCD, 8'hDD, 8'hD9, 8'hED, 8'hFD, 8'hF9:
                len = LEN_3;
            8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
            8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE:
                len = LEN_3;
            8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC,
            8'hEC:
                len = LEN_3;
            default:
                len = LEN_1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/if_len_decode.sv
// Combinational opcode-to-length decode for the fetch unit.
module if_len_decode
    import ie_defs::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = op_len(opcode);
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: reads 1..3 bytes over a one-cycle-latency byte port and
// presents a whole instruction to IE until it is accepted.
module if_fetch
    import ie_defs::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  ins_opcode,
    output logic [7:0]  ins_op1,
    output logic [7:0]  ins_op2,
    output logic [1:0]  ins_len,
    output logic [15:0] ins_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic [2:0]  dbg_state
);

    // Handshake: ins_valid is raised only in HOLD and the ins_* fields stay
    // frozen there; a transfer happens on any rising edge where ins_valid and
    // ins_ready are both 1, and ins_valid never drops without a transfer
    // unless redirect or rst flushes the instruction.

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   op1_q, op1_d;
    logic [7:0]   op2_q, op2_d;
    logic [1:0]   len_q, len_d;
    logic [15:0]  ipc_q, ipc_d;
    logic [1:0]   dec_len;

    if_len_decode u_len_decode (
        .opcode (mem_rdata),
        .len    (dec_len)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= REQ_OP;
            pc_q     <= RESET_PC;
            opcode_q <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            len_q    <= LEN_1;
            ipc_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
            ipc_q    <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_OP:  state_d = CAP_OP;
            CAP_OP:  state_d = (dec_len == LEN_1) ? HOLD : REQ_B1;
            REQ_B1:  state_d = CAP_B1;
            CAP_B1:  state_d = (len_q == LEN_2) ? HOLD : REQ_B2;
            REQ_B2:  state_d = CAP_B2;
            CAP_B2:  state_d = HOLD;
            HOLD:    state_d = ins_ready ? REQ_OP : HOLD;
            default: state_d = REQ_OP;
        endcase
        // A redirect also wins over a HOLD transfer; the transfer itself
        // still completes because ins_valid is up during this cycle.
        if (redirect) begin
            state_d = REQ_OP;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        ipc_d    = ipc_q;
        case (state_q)
            CAP_OP: begin
                opcode_d = mem_rdata;
                op1_d    = 8'h00;
                op2_d    = 8'h00;
                len_d    = dec_len;
                ipc_d    = pc_q;
                pc_d     = pc_q + 16'd1;
            end
            CAP_B1: begin
                op1_d = mem_rdata;
                pc_d  = pc_q + 16'd1;
            end
            CAP_B2: begin
                op2_d = mem_rdata;
                pc_d  = pc_q + 16'd1;
            end
            default: begin
            end
        endcase
        if (redirect) begin
            pc_d = redirect_addr;
        end
    end

    always_comb begin
        mem_addr   = pc_q;
        mem_rd     = (state_q == REQ_OP) || (state_q == REQ_B1) || (state_q == REQ_B2);
        ins_valid  = (state_q == HOLD);
        ins_opcode = opcode_q;
        ins_op1    = op1_q;
        ins_op2    = op2_q;
        ins_len    = len_q;
        ins_pc     = ipc_q;
        dbg_state  = state_q;
    end

endmodule
